// File: rtl/ex_wb_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ex_wb_buffer
// Description : In-order writeback FIFO between execute and register file,
//               with newest-first operand forwarding. Optional zero-latency
//               bypass when empty is enabled by the macro EX_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_wb_buffer #(
    parameter int DEPTH     = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    input  logic                 ex_stall,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_result,
    input  logic [4:0]           ex_dest_reg,
    input  logic                 ex_dest_reg_valid,
    input  logic                 ex_inval_dest_reg,
    output logic                 front_stall,
    input  logic                 wb_stall,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic [31:0]          rf_wpc,
    input  logic [4:0]           fwd_query_reg,
    output logic                 fwd_hit,
    output logic [31:0]          fwd_val,
    output logic [CNT_WIDTH-1:0] occupancy
);

    localparam logic [CNT_WIDTH-1:0] c_DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] c_PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [DEPTH-1:0]     r_vld;
    logic [DEPTH-1:0]     r_wen;
    logic [31:0]          r_pc   [DEPTH];
    logic [31:0]          r_res  [DEPTH];
    logic [4:0]           r_dest [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_wen_in;
    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_enq;

    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wen_in = ex_dest_reg_valid & ~ex_inval_dest_reg & (ex_dest_reg != 5'd0);
    // Full blocks the push even if the head drains this cycle.
    assign w_push   = ex_valid & ~ex_stall & ~w_full;
    assign w_pop    = ~w_empty & ~wb_stall;
`ifdef EX_WB_BYPASS_EN
    assign w_bypass = w_push & w_empty & ~wb_stall;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_enq    = w_push & ~w_bypass;

    assign front_stall = w_full;
    assign occupancy   = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_enq) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_enq && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_enq && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_pc[r_wr_ptr]   <= ex_pc;
            r_res[r_wr_ptr]  <= ex_result;
            r_dest[r_wr_ptr] <= ex_dest_reg;
            r_wen[r_wr_ptr]  <= w_wen_in;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        rf_wpc   = 32'd0;
        if (!w_empty) begin
            rf_we    = w_pop & r_wen[r_rd_ptr];
            rf_waddr = r_dest[r_rd_ptr];
            rf_wdata = r_res[r_rd_ptr];
            rf_wpc   = r_pc[r_rd_ptr];
        end
        if (w_bypass) begin
            rf_we    = w_wen_in;
            rf_waddr = ex_dest_reg;
            rf_wdata = ex_result;
            rf_wpc   = ex_pc;
        end
    end

    // Walk oldest to newest so the newest match overrides earlier ones.
    always_comb begin
        logic [PTR_WIDTH-1:0] w_idx;
        fwd_hit = 1'b0;
        fwd_val = 32'd0;
        w_idx   = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_WIDTH'(k);
            if (r_vld[w_idx] && r_wen[w_idx] && (fwd_query_reg != 5'd0) &&
                (r_dest[w_idx] == fwd_query_reg)) begin
                fwd_hit = 1'b1;
                fwd_val = r_res[w_idx];
            end
        end
    end

    a_no_push_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(w_enq && w_full));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset_n)
        !(w_pop && w_empty));

endmodule
`default_nettype wire

// File: tb/tb_ex_wb_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ex_wb_buffer
// Description : Scoreboard bench for ex_wb_buffer (register-file writes,
//               forwarding, back-pressure and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_wb_buffer;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef EX_WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          ex_valid, ex_stall, ex_dest_reg_valid, ex_inval_dest_reg;
    logic [31:0]   ex_pc, ex_result;
    logic [4:0]    ex_dest_reg;
    logic          front_stall, wb_stall, rf_we, fwd_hit;
    logic [4:0]    rf_waddr, fwd_query_reg;
    logic [31:0]   rf_wdata, rf_wpc, fwd_val;
    logic [CW-1:0] occupancy;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } wb_t;
    wb_t sb_q[$];

    always #5 clock = ~clock;

    ex_wb_buffer #(.DEPTH(DEPTH)) u_dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ex_valid          (ex_valid),
        .ex_stall          (ex_stall),
        .ex_pc             (ex_pc),
        .ex_result         (ex_result),
        .ex_dest_reg       (ex_dest_reg),
        .ex_dest_reg_valid (ex_dest_reg_valid),
        .ex_inval_dest_reg (ex_inval_dest_reg),
        .front_stall       (front_stall),
        .wb_stall          (wb_stall),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .rf_wpc            (rf_wpc),
        .fwd_query_reg     (fwd_query_reg),
        .fwd_hit           (fwd_hit),
        .fwd_val           (fwd_val),
        .occupancy         (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    initial begin
        wb_t e;
        forever begin
            @(negedge clock);
            if (reset_n && rf_we) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_we", {27'd0, rf_waddr}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wb_addr", {27'd0, rf_waddr}, {27'd0, e.a});
                    chk("wb_data", rf_wdata, e.d);
                    chk("wb_pc", rf_wpc, e.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] res,
                          input logic [4:0] dest, input logic dv, input logic inval);
        wb_t e;
        ex_pc = pc; ex_result = res; ex_dest_reg = dest;
        ex_dest_reg_valid = dv; ex_inval_dest_reg = inval;
        ex_valid = 1'b1;
        if (dv && !inval && dest != 5'd0) begin
            e.a = dest; e.d = res; e.pc = pc;
            sb_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_push(input logic [31:0] pc, input logic [31:0] res,
                              input logic [4:0] dest, input logic dv, input logic inval);
        bit acc;
        set_ex(pc, res, dest, dv, inval);
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            if (!ex_stall && !front_stall) acc = 1'b1;
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        ex_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fs"},    {31'd0, front_stall}, 32'd0);
        chk({tag, "_we"},    {31'd0, rf_we}, 32'd0);
        chk({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
        chk({tag, "_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_wpc"},   rf_wpc, 32'd0);
        chk({tag, "_hit"},   {31'd0, fwd_hit}, 32'd0);
        chk({tag, "_val"},   fwd_val, 32'd0);
        chk({tag, "_occ"},   32'(occupancy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_stall = 1'b0;
        ex_pc = '0; ex_result = '0; ex_dest_reg = '0;
        ex_dest_reg_valid = 1'b0; ex_inval_dest_reg = 1'b0;
        wb_stall = 1'b0; fwd_query_reg = '0;

        // Reset state
        @(negedge clock);
        chk_all_zero("rst");
        @(posedge clock); #1 reset_n = 1'b1;

        // Single push, written the following cycle
        drive_push(32'h100, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
        @(negedge clock);
        chk("t1_occ", 32'(occupancy), c_BYP ? 32'd0 : 32'd1);
        @(negedge clock);
        chk("t1_occ_drained", 32'(occupancy), 32'd0);

        // Fill under wb_stall, third instruction held off
        @(posedge clock); #1 wb_stall = 1'b1;
        drive_push(32'h110, 32'h33, 5'd3, 1'b1, 1'b0);
        drive_push(32'h114, 32'h44, 5'd4, 1'b1, 1'b0);
        @(negedge clock);
        chk("t2_occ_full", 32'(occupancy), 32'd2);
        chk("t2_fs_full", {31'd0, front_stall}, 32'd1);
        @(posedge clock); #1 set_ex(32'h118, 32'h99, 5'd9, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clock);
            chk("t2_not_accepted", 32'(occupancy), 32'd2);
        end
        @(posedge clock); #1 wb_stall = 1'b0;
        @(negedge clock);
        chk("t2_fs_first_pop", {31'd0, front_stall}, 32'd1);
        chk("t2_we_r3", {31'd0, rf_we}, 32'd1);
        @(negedge clock);
        chk("t2_fs_after_pop", {31'd0, front_stall}, 32'd0);
        chk("t2_we_r4", {31'd0, rf_we}, 32'd1);
        @(posedge clock); #1 ex_valid = 1'b0;
        @(negedge clock);
        chk("t2_occ_r9", 32'(occupancy), 32'd1);
        @(negedge clock);
        chk("t2_occ_empty", 32'(occupancy), 32'd0);

        // Forwarding: newest match wins, no-hit and r0 cases
        @(posedge clock); #1 wb_stall = 1'b1;
        drive_push(32'h200, 32'd1, 5'd7, 1'b1, 1'b0);
        drive_push(32'h204, 32'd2, 5'd7, 1'b1, 1'b0);
        fwd_query_reg = 5'd7;
        @(negedge clock);
        chk("t3_hit7", {31'd0, fwd_hit}, 32'd1);
        chk("t3_val7", fwd_val, 32'd2);
        fwd_query_reg = 5'd8; #1;
        chk("t3_hit8", {31'd0, fwd_hit}, 32'd0);
        chk("t3_val8", fwd_val, 32'd0);
        fwd_query_reg = 5'd0; #1;
        chk("t3_hit0", {31'd0, fwd_hit}, 32'd0);
        fwd_query_reg = 5'd7;
        @(posedge clock); #1 wb_stall = 1'b0;
        @(negedge clock);
        chk("t3_hit_popping", fwd_val, 32'd2);
        @(negedge clock);
        chk("t3_hit_last", {31'd0, fwd_hit}, 32'd1);
        chk("t3_val_last", fwd_val, 32'd2);
        @(negedge clock);
        chk("t3_hit_drained", {31'd0, fwd_hit}, 32'd0);

        // Entries that write nothing still drain
        @(posedge clock); #1 wb_stall = 1'b1;
        drive_push(32'h300, 32'h55, 5'd0, 1'b1, 1'b0);
        drive_push(32'h304, 32'h66, 5'd5, 1'b1, 1'b1);
        @(negedge clock);
        chk("t4_occ", 32'(occupancy), 32'd2);
        fwd_query_reg = 5'd5; #1;
        chk("t4_hit_inval", {31'd0, fwd_hit}, 32'd0);
        fwd_query_reg = 5'd0; #1;
        chk("t4_hit_r0", {31'd0, fwd_hit}, 32'd0);
        @(posedge clock); #1 wb_stall = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("t4_no_we", {31'd0, rf_we}, 32'd0);
        end
        @(negedge clock);
        chk("t4_occ_drained", 32'(occupancy), 32'd0);

        // Stalled multi-cycle result against a full buffer
        @(posedge clock); #1 wb_stall = 1'b1;
        drive_push(32'h400, 32'hA0A0, 5'd10, 1'b1, 1'b0);
        drive_push(32'h404, 32'hB0B0, 5'd11, 1'b1, 1'b0);
        ex_stall = 1'b1;
        set_ex(32'h500, 32'h12345678, 5'd12, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clock);
            chk("t5_occ_full", 32'(occupancy), 32'd2);
        end
        @(posedge clock); #1 wb_stall = 1'b0;
        repeat (3) @(negedge clock);
        chk("t5_no_push_stalled", 32'(occupancy), 32'd0);
        @(posedge clock); #1 ex_stall = 1'b0;
        @(negedge clock);
        chk("t5_fs", {31'd0, front_stall}, 32'd0);
        @(posedge clock); #1 ex_valid = 1'b0;
        @(negedge clock);
        chk("t5_occ_mul", 32'(occupancy), c_BYP ? 32'd0 : 32'd1);
        @(negedge clock);
        chk("t5_occ_drained", 32'(occupancy), 32'd0);

        // Reset while holding two entries
        @(posedge clock); #1 wb_stall = 1'b1;
        drive_push(32'h600, 32'hCAFE, 5'd20, 1'b1, 1'b0);
        drive_push(32'h604, 32'hBEEF, 5'd21, 1'b1, 1'b0);
        fwd_query_reg = 5'd20;
        @(negedge clock);
        chk("t6_occ", 32'(occupancy), 32'd2);
        chk("t6_hit", {31'd0, fwd_hit}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("t6_rst");
        sb_q.delete();
        @(posedge clock); #1 reset_n = 1'b1; wb_stall = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_occ_after", 32'(occupancy), 32'd0);
        chk("t6_hit_after", {31'd0, fwd_hit}, 32'd0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
